accum_lanes: RTL and testbench

ACCUM_LANES -- requirements
Module: accum_lanes

---
 rtl/accum_lanes.sv | 126 ++++++++++++
 tb/tb_accum_lanes.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_lanes.sv
// accum_lanes: multi-lane signed vector accumulator with per-lane bias,
// optional saturation, sticky per-lane overflow and a beat counter.
// A vector is absorbed beat by beat in ACCUM and presented in DRAIN until
// the consumer takes it.
module accum_lanes #(
    parameter int BITS     = 32,
    parameter int LANES    = 4,
    parameter int SATURATE = 1,
    localparam int IN_W    = BITS + 17,
    localparam int ACC_W   = BITS + 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_last,
    input  logic [LANES*ACC_W-1:0] bias_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_data,
    output logic [LANES-1:0]       out_ovf,
    output logic [31:0]            out_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   state_q, state_d;
    logic                     first_q, first_d;
    logic [LANES*ACC_W-1:0]   acc_q, acc_d;
    logic [LANES-1:0]         ovf_q, ovf_d;
    logic [31:0]              count_q, count_d;

    logic [ACC_W-1:0]         lane_res [LANES];
    logic                     lane_ovf [LANES];

    // Per-lane adder: one guard bit above ACC_W exposes overflow as a
    // disagreement between the two top bits of the sum.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [ACC_W-1:0] base;
        logic [IN_W-1:0]  operand;
        logic [ACC_W:0]   sum;

        assign base     = first_q ? bias_in[g*ACC_W +: ACC_W] : acc_q[g*ACC_W +: ACC_W];
        assign operand  = in_data[g*IN_W +: IN_W];
        assign sum      = {base[ACC_W-1], base}
                        + {{(ACC_W+1-IN_W){operand[IN_W-1]}}, operand};
        assign lane_ovf[g] = sum[ACC_W] ^ sum[ACC_W-1];
        assign lane_res[g] = (lane_ovf[g] && (SATURATE != 0))
                           ? (sum[ACC_W] ? MIN_NEG : MAX_POS)
                           : sum[ACC_W-1:0];
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

    // Next-state logic: clear beats a beat or a handshake in the same cycle.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        first_d = first_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        if (clear) begin
            state_d = ACCUM;
            first_d = 1'b1;
            ovf_d   = '0;
            count_d = '0;
        end else if (state_q == ACCUM) begin
            if (in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i*ACC_W +: ACC_W] = lane_res[i];
                    // ovf_q is already zero on a first beat, so OR keeps it sticky.
                    ovf_d[i] = ovf_q[i] | lane_ovf[i];
                end
                count_d = first_q ? 32'd1 : count_q + 32'd1;
                first_d = 1'b0;
                if (in_last) begin
                    state_d = DRAIN;
                end
            end
        end else begin
            if (out_ready) begin
                state_d = ACCUM;
                first_d = 1'b1;
                ovf_d   = '0;
                count_d = '0;
            end
        end
    end

    // State register with asynchronous reset of every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            first_q <= 1'b1;
            // NOTE: the accumulators are reset too, because the outputs
            // must read zero while reset is held, not just the control state.
            acc_q   <= '0;
            ovf_q   <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_accum_lanes.sv
// tb_accum_lanes: directed bench for accum_lanes with BITS=8, LANES=2.
// Two instances share all inputs: one saturating, one wrapping.
module tb_accum_lanes;

    localparam int BITS  = 8;
    localparam int LANES = 2;
    localparam int IN_W  = BITS + 17;
    localparam int ACC_W = BITS + 25;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear;
    logic                   in_valid;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   in_last;
    logic [LANES*ACC_W-1:0] bias_in;
    logic                   out_ready;

    logic                   in_ready_s, out_valid_s;
    logic [LANES*ACC_W-1:0] out_data_s;
    logic [LANES-1:0]       out_ovf_s;
    logic [31:0]            out_count_s;

    logic                   in_ready_w, out_valid_w;
    logic [LANES*ACC_W-1:0] out_data_w;
    logic [LANES-1:0]       out_ovf_w;
    logic [31:0]            out_count_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accum_lanes #(.BITS(BITS), .LANES(LANES), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_last(in_last), .bias_in(bias_in),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_ovf(out_ovf_s), .out_count(out_count_s)
    );

    accum_lanes #(.BITS(BITS), .LANES(LANES), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .in_last(in_last), .bias_in(bias_in),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_ovf(out_ovf_w), .out_count(out_count_w)
    );

    function automatic logic [LANES*IN_W-1:0] pack_in(input int a, input int b);
        logic [IN_W-1:0] x, y;
        x = a[IN_W-1:0];
        y = b[IN_W-1:0];
        return {y, x};
    endfunction

    function automatic logic [LANES*ACC_W-1:0] pack_bias(input longint a, input longint b);
        logic [ACC_W-1:0] x, y;
        x = a[ACC_W-1:0];
        y = b[ACC_W-1:0];
        return {y, x};
    endfunction

    function automatic longint lane(input logic [LANES*ACC_W-1:0] v, input int i);
        logic signed [ACC_W-1:0] s;
        s = v[i*ACC_W +: ACC_W];
        return longint'(s);
    endfunction

    // One accepted beat: drive, take the edge, sample 1 time unit later.
    task automatic beat(input int a, input int b, input logic last);
        in_valid = 1'b1;
        in_data  = pack_in(a, b);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; bias_in = '0; out_ready = 1'b0;
        #2;
        n_checks++;
        if (in_ready_s !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_s); end
        n_checks++;
        if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_s); end
        n_checks++;
        if (out_data_s !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data_s); end
        n_checks++;
        if (out_ovf_s !== 2'b00 || out_count_s !== 32'd0) begin
            n_fail++; $display("FAIL reset_ovf_count: got ovf=%b count=%0d expected 00/0", out_ovf_s, out_count_s);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_vector();
        bias_in = pack_bias(5, -3);
        beat(10, 1, 1'b0);
        beat(20, 2, 1'b0);
        n_checks++;
        if (out_valid_s !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_valid: got %b expected 0", out_valid_s); end
        beat(-4, 7, 1'b1);
        n_checks++;
        if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin
            n_fail++; $display("FAIL basic_valid: got valid=%b ready=%b expected 1/0", out_valid_s, in_ready_s);
        end
        n_checks++;
        if (lane(out_data_s, 0) !== 64'sd31) begin n_fail++; $display("FAIL basic_lane0: got %0d expected 31", lane(out_data_s, 0)); end
        n_checks++;
        if (lane(out_data_s, 1) !== 64'sd7) begin n_fail++; $display("FAIL basic_lane1: got %0d expected 7", lane(out_data_s, 1)); end
        n_checks++;
        if (out_count_s !== 32'd3 || out_ovf_s !== 2'b00) begin
            n_fail++; $display("FAIL basic_count_ovf: got count=%0d ovf=%b expected 3/00", out_count_s, out_ovf_s);
        end
        handshake();
        n_checks++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1 || out_count_s !== 32'd0) begin
            n_fail++; $display("FAIL basic_after_handshake: got valid=%b ready=%b count=%0d expected 0/1/0",
                               out_valid_s, in_ready_s, out_count_s);
        end
    endtask

    task automatic test_backpressure();
        bias_in = pack_bias(5, -3);
        beat(10, 1, 1'b1);
        // Offer beats while the consumer stalls; none may be absorbed.
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = pack_in(100, 100);
            @(posedge clk); #1;
            n_checks++;
            if (in_ready_s !== 1'b0 || out_valid_s !== 1'b1 || lane(out_data_s, 0) !== 64'sd15
                || lane(out_data_s, 1) !== -64'sd2 || out_count_s !== 32'd1) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got ready=%b valid=%b l0=%0d l1=%0d count=%0d expected 0/1/15/-2/1",
                         c, in_ready_s, out_valid_s, lane(out_data_s, 0), lane(out_data_s, 1), out_count_s);
            end
        end
        // Handshake while in_valid is still high: the beat must not be taken.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        bias_in = pack_bias(1, 2);
        beat(3, 4, 1'b1);
        n_checks++;
        if (lane(out_data_s, 0) !== 64'sd4 || lane(out_data_s, 1) !== 64'sd6 || out_count_s !== 32'd1) begin
            n_fail++; $display("FAIL backpressure_next: got l0=%0d l1=%0d count=%0d expected 4/6/1",
                               lane(out_data_s, 0), lane(out_data_s, 1), out_count_s);
        end
        handshake();
    endtask

    task automatic test_overflow();
        bias_in = pack_bias(64'sd4294967286, 0);
        beat(20, 0, 1'b1);
        n_checks++;
        if (lane(out_data_s, 0) !== 64'sd4294967295 || out_ovf_s !== 2'b01) begin
            n_fail++; $display("FAIL sat_pos: got l0=%0d ovf=%b expected 4294967295/01", lane(out_data_s, 0), out_ovf_s);
        end
        n_checks++;
        if (lane(out_data_w, 0) !== -64'sd4294967286 || out_ovf_w !== 2'b01) begin
            n_fail++; $display("FAIL wrap_pos: got l0=%0d ovf=%b expected -4294967286/01", lane(out_data_w, 0), out_ovf_w);
        end
        n_checks++;
        if (lane(out_data_s, 1) !== 64'sd0) begin n_fail++; $display("FAIL sat_other_lane: got %0d expected 0", lane(out_data_s, 1)); end
        handshake();
        bias_in = pack_bias(0, 0);
        beat(1, 1, 1'b1);
        n_checks++;
        if (out_ovf_s !== 2'b00 || out_ovf_w !== 2'b00 || lane(out_data_s, 0) !== 64'sd1) begin
            n_fail++; $display("FAIL ovf_cleared: got sat_ovf=%b wrap_ovf=%b l0=%0d expected 00/00/1",
                               out_ovf_s, out_ovf_w, lane(out_data_s, 0));
        end
        handshake();
        // Negative clamp on lane 1.
        bias_in = pack_bias(0, -64'sd4294967296);
        beat(0, -1, 1'b1);
        n_checks++;
        if (lane(out_data_s, 1) !== -64'sd4294967296 || lane(out_data_w, 1) !== 64'sd4294967295
            || out_ovf_s !== 2'b10 || out_ovf_w !== 2'b10) begin
            n_fail++; $display("FAIL neg_edge: got sat=%0d wrap=%0d ovf=%b/%b expected -4294967296/4294967295/10/10",
                               lane(out_data_s, 1), lane(out_data_w, 1), out_ovf_s, out_ovf_w);
        end
        handshake();
        // Sticky: overflow on the first beat, none on the second.
        bias_in = pack_bias(64'sd4294967286, 0);
        beat(20, 0, 1'b0);
        beat(-5, 0, 1'b1);
        n_checks++;
        if (lane(out_data_s, 0) !== 64'sd4294967290 || out_ovf_s !== 2'b01 || out_count_s !== 32'd2) begin
            n_fail++; $display("FAIL sat_sticky: got l0=%0d ovf=%b count=%0d expected 4294967290/01/2",
                               lane(out_data_s, 0), out_ovf_s, out_count_s);
        end
        n_checks++;
        if (lane(out_data_w, 0) !== -64'sd4294967291 || out_ovf_w !== 2'b01) begin
            n_fail++; $display("FAIL wrap_sticky: got l0=%0d ovf=%b expected -4294967291/01", lane(out_data_w, 0), out_ovf_w);
        end
        handshake();
    endtask

    task automatic test_clear();
        bias_in = pack_bias(100, 100);
        beat(1, 1, 1'b0);
        clear = 1'b1;
        beat(1, 1, 1'b1);
        clear = 1'b0;
        n_checks++;
        if (out_valid_s !== 1'b0 || out_count_s !== 32'd0 || in_ready_s !== 1'b1) begin
            n_fail++; $display("FAIL clear_accum: got valid=%b count=%0d ready=%b expected 0/0/1",
                               out_valid_s, out_count_s, in_ready_s);
        end
        bias_in = pack_bias(0, 0);
        beat(7, 7, 1'b1);
        n_checks++;
        if (lane(out_data_s, 0) !== 64'sd7 || lane(out_data_s, 1) !== 64'sd7 || out_count_s !== 32'd1) begin
            n_fail++; $display("FAIL clear_next: got l0=%0d l1=%0d count=%0d expected 7/7/1",
                               lane(out_data_s, 0), lane(out_data_s, 1), out_count_s);
        end
        // Clear in DRAIN wins over a simultaneous handshake.
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (out_valid_s !== 1'b0 || out_count_s !== 32'd0 || out_ovf_s !== 2'b00) begin
            n_fail++; $display("FAIL clear_drain: got valid=%b count=%0d ovf=%b expected 0/0/00",
                               out_valid_s, out_count_s, out_ovf_s);
        end
    endtask

    task automatic test_async_reset();
        bias_in = pack_bias(64'sd4294967286, 9);
        beat(20, 1, 1'b0);
        beat(1, 1, 1'b1);
        n_checks++;
        if (out_valid_s !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got %b expected 1", out_valid_s); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
            n_fail++; $display("FAIL areset_flags: got valid=%b ready=%b expected 0/1", out_valid_s, in_ready_s);
        end
        n_checks++;
        if (out_data_s !== '0 || out_ovf_s !== 2'b00 || out_count_s !== 32'd0) begin
            n_fail++; $display("FAIL areset_outputs: got data=%h ovf=%b count=%0d expected 0/00/0",
                               out_data_s, out_ovf_s, out_count_s);
        end
        #1 rst = 1'b0;
        bias_in = pack_bias(2, 3);
        beat(1, 1, 1'b1);
        n_checks++;
        if (lane(out_data_s, 0) !== 64'sd3 || lane(out_data_s, 1) !== 64'sd4 || out_count_s !== 32'd1) begin
            n_fail++; $display("FAIL areset_next: got l0=%0d l1=%0d count=%0d expected 3/4/1",
                               lane(out_data_s, 0), lane(out_data_s, 1), out_count_s);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic_vector();
        test_backpressure();
        test_overflow();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
